// File: rtl/sprite_reg_writer_if.sv
// sprite_reg_writer_if: command queue handshake plus Avalon-MM write port of the sprite register writer
// master: the writer (consumes commands, drives Avalon); slave: the environment (pushes commands, models responder)
interface sprite_reg_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [8:0]  avm_address;
  logic [31:0] avm_writedata;
  logic        avm_write;
  logic        avm_chipselect;
  logic        avm_waitrequest;
  modport master (
    input  cmd_valid, cmd_addr, cmd_data, avm_waitrequest,
    output cmd_ready, avm_address, avm_writedata, avm_write, avm_chipselect
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_data, avm_waitrequest,
    input  cmd_ready, avm_address, avm_writedata, avm_write, avm_chipselect
  );
endinterface

// File: rtl/sprite_reg_writer.sv
// sprite_reg_writer: queues sprite register updates and issues them as Avalon writes inside the vblank window
// clk, reset (async, active low); vblank level input; bus: command queue + Avalon write port;
// fifo_count occupancy, busy (queued or in flight), frame_writes completed writes this window (saturating)
module sprite_reg_writer #(
  parameter int DEPTH          = 8,
  parameter int MAX_PER_FRAME  = 16,
  parameter int GATE_ON_VBLANK = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vblank,
  sprite_reg_writer_if.master      bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic [7:0]               frame_writes
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [7:0] MAX_B = 8'(MAX_PER_FRAME);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t state_q, state_d;
  logic [40:0] fifo_mem [DEPTH];
  logic [40:0] head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [8:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic write_q, write_d, vblank_q;
  logic [7:0] budget_q, budget_d, budget_base, frame_q, frame_d, frame_base;
  logic room, push, launch, done, win_open, vb_rise, under;
  always_comb begin
    head        = fifo_mem[rd_ptr_q];
    room        = count_q != FULL;
    push        = bus.cmd_valid && room;
    win_open    = (GATE_ON_VBLANK == 0) || vblank;
    vb_rise     = (GATE_ON_VBLANK != 0) && vblank && !vblank_q;
    under       = (MAX_PER_FRAME == 0) || (budget_q < MAX_B);
    launch      = state_q == IDLE && count_q != '0 && win_open && under;
    done        = state_q == ISSUE && !bus.avm_waitrequest;
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(launch);
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(launch);
    addr_d      = launch ? head[40:32] : addr_q;
    data_d      = launch ? head[31:0] : data_q;
    write_d     = launch || (state_q == ISSUE && bus.avm_waitrequest);
    // a window-opening clear lands first, then a completion in the same cycle counts into the new window
    budget_base = vb_rise ? 8'd0 : budget_q;
    frame_base  = vb_rise ? 8'd0 : frame_q;
    budget_d    = budget_base + 8'(done);
    frame_d     = frame_base + 8'(done && frame_base != 8'hff);
    state_d     = state_q == IDLE  ? (launch ? ISSUE : IDLE) :
                  state_q == ISSUE ? (done ? GAP : ISSUE) : IDLE;
  end
  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr_q] <= {bus.cmd_addr, bus.cmd_data};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      budget_q <= '0;
      frame_q  <= '0;
      vblank_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      write_q  <= write_d;
      budget_q <= budget_d;
      frame_q  <= frame_d;
      vblank_q <= vblank;
    end
  assign bus.cmd_ready      = room;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = data_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_chipselect = write_q;
  assign fifo_count         = count_q;
  assign busy               = count_q != '0 || state_q != IDLE;
  assign frame_writes       = frame_q;
endmodule

// File: doc/sprite_reg_writer.md
Name: sprite_reg_writer

Overview:
Avalon-MM write initiator that drives the register port of the sprite display responder. Software or game-logic blocks push register updates through a valid/ready queue, for example sprite X at address 0 and sprite Y at address 1. The block buffers these updates in a FIFO and issues them as single-word Avalon writes, only inside the vertical-blank window, so that sprite position never changes mid-frame. A per-frame write budget bounds bus occupancy.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
MAX_PER_FRAME, 16, maximum writes issued per vertical-blank window; 0 means unlimited.
GATE_ON_VBLANK, 1, 1 = issue only while vblank is high; 0 = issue whenever the FIFO is non-empty.

Ports:
clk  in  1  system clock (50 MHz).
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  update request valid.
cmd_ready  out  1  FIFO can accept; high when not full.
cmd_addr  in  9  target register address.
cmd_data  in  32  target register data.
vblank  in  1  level; high during vertical blanking, synchronous to clk.
avm_address  out  9  Avalon address.
avm_writedata  out  32  Avalon write data.
avm_write  out  1  Avalon write strobe.
avm_chipselect  out  1  equals avm_write.
avm_waitrequest  in  1  responder stall; tie to 0 for a zero-wait responder.
fifo_count  out  log2(DEPTH)+1  current occupancy.
busy  out  1  high when the FIFO is non-empty or a write is in flight.
frame_writes  out  8  writes completed in the current/last window; saturates at 255.

Behaviour:
Reset (reset low, asynchronous):
- FIFO empty; fifo_count=0; cmd_ready=1.
- avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0.
- busy=0; frame_writes=0; state=IDLE; budget counter=0.

FIFO:
- Push occurs when cmd_valid & cmd_ready at the clock edge.
- Pop occurs when IDLE launches a write; the head is latched into avm_address/avm_writedata.
- Push and pop in the same cycle leave the count unchanged.
- When full, cmd_ready=0; no push occurs and no data is lost. Push-when-full is not legal.
- There is no bypass: an entry pushed at edge N can launch at the earliest at edge N+1.
- Pointers wrap modulo DEPTH.

Window:
- win_open = vblank when GATE_ON_VBLANK=1; otherwise constant 1.
- A rising edge of vblank (registered compare) clears the budget counter and frame_writes in the same cycle.
- When GATE_ON_VBLANK=0, the budget is never cleared, so MAX_PER_FRAME must be 0.

State machine:
- IDLE:
  - Launch when FIFO non-empty, win_open=1, and (MAX_PER_FRAME==0 or budget<MAX_PER_FRAME).
  - On launch, register avm_write=1 with the head address/data, pop the FIFO, and go to ISSUE.
  - Otherwise hold with avm_write=0.
- ISSUE:
  - avm_write, avm_address and avm_writedata stay stable while avm_waitrequest=1.
  - The transfer completes at the first edge with avm_waitrequest=0.
  - On completion: avm_write<=0, budget+1, frame_writes+1 (saturating), go to GAP.
- GAP:
  - One idle cycle with avm_write=0, then go to IDLE.
  - Minimum spacing is 3 cycles per write. This guarantees the strobe deasserts between writes for responders that sample write as a level.

Boundary conditions:
- vblank falls during ISSUE: the transfer completes; it is never aborted. No new launch occurs after the window closes.
- A rising edge of vblank coinciding with a completion: the clear takes priority, then the count applies, so budget=1 and frame_writes=1.
- Budget exhausted: entries stay queued until the next window, in original order.
- Reset asserted mid-transfer: avm_write drops immediately (asynchronously); queued entries are discarded.
- busy = (fifo_count!=0) | (state!=IDLE).

Test Plan:
- Gated issue: vblank=0, push (0,0x40) then (1,0x60). Required: no avm_write and fifo_count=2. Raise vblank: writes to addr 0 data 0x40 and addr 1 data 0x60, in order, 3 cycles apart. Then fifo_count=0, frame_writes=2.
- Waitrequest stall: hold avm_waitrequest=1 for 5 cycles during ISSUE. Required: address/data/write stable for 6 cycles; a single completion; frame_writes increments by 1 only.
- Full/backpressure: DEPTH=8, vblank=0, push 9 times with cmd_valid held. Required: cmd_ready=0 after 8 pushes; fifo_count=8; the 9th entry is accepted only after the first pop in the next window.
- Budget: MAX_PER_FRAME=2, 5 queued entries, one vblank pulse lasting 100 cycles. Required: exactly 2 writes. Next pulse: 2 writes. Third pulse: 1 write, strictly FIFO order.
- Window close mid-transfer: drop vblank while avm_waitrequest=1. Required: the transfer completes when waitrequest falls; no further launches; remaining entries are held.
- Async reset: assert reset low mid-ISSUE, between clock edges. Required: avm_write=0 immediately; fifo_count=0; cmd_ready=1; busy=0 after release.
